// File: rtl/ac_motor_vector_gate.sv
// Space-vector gate driver: decodes sector/phase-select into per-leg targets,
// then enforces an independent dead-time on each inverter leg.

module ac_motor_vector_gate_leg #(
    parameter int DEAD_CYCLES = 100
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_kill,
    input  logic [1:0] i_tgt,
    output logic       o_gh,
    output logic       o_gl
);
    localparam logic [1:0] TGT_LOW  = 2'd1;
    localparam logic [1:0] TGT_HIGH = 2'd2;
    localparam logic [1:0] TGT_OFF  = 2'd0;
    localparam logic [7:0] LP_DEAD  = 8'(DEAD_CYCLES);

    logic [1:0] r_seen;
    logic [7:0] r_cnt;
    logic       r_gh, r_gl;
    logic       w_change, w_follow;
    logic [7:0] w_cnt_nxt;

    // The gate for a new target is released on the edge the counter reaches zero.
    always_comb begin
        w_change  = (i_tgt != r_seen);
        w_follow  = 1'b0;
        w_cnt_nxt = 8'd0;
        if (w_change) begin
            w_cnt_nxt = LP_DEAD;
            w_follow  = (LP_DEAD == 8'd0);
        end else if (r_cnt > 8'd1) begin
            w_cnt_nxt = r_cnt - 8'd1;
        end else begin
            w_follow  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_seen <= TGT_OFF;
            r_cnt  <= 8'd0;
            r_gh   <= 1'b0;
            r_gl   <= 1'b0;
        end else begin
            r_seen <= i_tgt;
            r_cnt  <= w_cnt_nxt;
            r_gh   <= w_follow && !i_kill && (i_tgt == TGT_HIGH);
            r_gl   <= w_follow && !i_kill && (i_tgt == TGT_LOW);
        end
    end

    assign o_gh = r_gh;
    assign o_gl = r_gl;
endmodule

module ac_motor_vector_gate #(
    parameter int DEAD_CYCLES = 100,
    parameter int ZERO_MODE   = 2
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_enable,
    input  logic [2:0] i_sector_in,
    input  logic       i_u_0,
    input  logic       i_u_low,
    input  logic       i_u_high,
    output logic       o_gate_ah,
    output logic       o_gate_al,
    output logic       o_gate_bh,
    output logic       o_gate_bl,
    output logic       o_gate_ch,
    output logic       o_gate_cl,
    output logic [2:0] o_phase_state,
    output logic       o_fault
);
    localparam logic [1:0] TGT_OFF  = 2'd0;
    localparam logic [1:0] TGT_LOW  = 2'd1;
    localparam logic [1:0] TGT_HIGH = 2'd2;

    // Leg index 2 = A, 1 = B, 0 = C, matching the {A,B,C} vector notation.
    logic [2:0][1:0] r_tgt;
    logic [2:0]      r_last_vec;
    logic            r_fault;

    logic       w_onehot, w_bad, w_fault_nxt, w_drive, w_kill;
    logic [2:0] w_lo_idx, w_hi_idx, w_zero_vec, w_vec;
    logic [2:0] w_gh, w_gl;

    function automatic logic [2:0] f_vec(input logic [2:0] idx);
        case (idx)
            3'd1:    f_vec = 3'b100;
            3'd2:    f_vec = 3'b110;
            3'd3:    f_vec = 3'b010;
            3'd4:    f_vec = 3'b011;
            3'd5:    f_vec = 3'b001;
            3'd6:    f_vec = 3'b101;
            default: f_vec = 3'b000;
        endcase
    endfunction

    always_comb begin
        w_onehot    = ({i_u_0, i_u_low, i_u_high} == 3'b100) ||
                      ({i_u_0, i_u_low, i_u_high} == 3'b010) ||
                      ({i_u_0, i_u_low, i_u_high} == 3'b001);
        w_bad       = i_enable && (!w_onehot || (i_sector_in > 3'd5));
        w_fault_nxt = r_fault || w_bad;
        w_drive     = i_enable && !w_fault_nxt;
        w_kill      = !i_enable || w_fault_nxt;
        w_lo_idx    = 3'(i_sector_in + 3'd1);
        w_hi_idx    = (i_sector_in == 3'd5) ? 3'd1 : 3'(i_sector_in + 3'd2);
        // Nearest zero: V7 after a two-high vector saves switching two legs.
        if (ZERO_MODE == 0)
            w_zero_vec = 3'b000;
        else if (ZERO_MODE == 1)
            w_zero_vec = 3'b111;
        else if ((r_last_vec == 3'b110) || (r_last_vec == 3'b011) || (r_last_vec == 3'b101))
            w_zero_vec = 3'b111;
        else
            w_zero_vec = 3'b000;
        if (i_u_0)
            w_vec = w_zero_vec;
        else if (i_u_low)
            w_vec = f_vec(w_lo_idx);
        else
            w_vec = f_vec(w_hi_idx);
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_tgt      <= {3{TGT_OFF}};
            r_last_vec <= 3'b100;
            r_fault    <= 1'b0;
        end else begin
            r_fault <= w_fault_nxt;
            for (int l = 0; l < 3; l++)
                r_tgt[l] <= !w_drive ? TGT_OFF : (w_vec[l] ? TGT_HIGH : TGT_LOW);
            if (w_drive && !i_u_0)
                r_last_vec <= w_vec;
        end
    end

    for (genvar l = 0; l < 3; l++) begin : g_leg
        ac_motor_vector_gate_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .i_kill    (w_kill),
            .i_tgt     (r_tgt[l]),
            .o_gh      (w_gh[l]),
            .o_gl      (w_gl[l])
        );
        assign o_phase_state[l] = (r_tgt[l] == TGT_HIGH);
    end

    assign o_gate_ah = w_gh[2];
    assign o_gate_al = w_gl[2];
    assign o_gate_bh = w_gh[1];
    assign o_gate_bl = w_gl[1];
    assign o_gate_ch = w_gh[0];
    assign o_gate_cl = w_gl[0];
    assign o_fault   = r_fault;
endmodule

// File: tb/tb_ac_motor_vector_gate.sv
// Directed bench: dead-time 4 / nearest-zero instance and a dead-time 0 / V7 instance
// share the same stimulus; gate vectors are packed {AH,AL,BH,BL,CH,CL}.

module tb_ac_motor_vector_gate;
    logic       clk = 1'b0;
    logic       reset_n, enable, u0, ulow, uhigh;
    logic [2:0] sector;

    logic       a4h, a4l, b4h, b4l, c4h, c4l, f4;
    logic [2:0] p4;
    logic       a0h, a0l, b0h, b0l, c0h, c0l, f0;
    logic [2:0] p0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ac_motor_vector_gate #(.DEAD_CYCLES(4), .ZERO_MODE(2)) dut4 (
        .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_sector_in(sector),
        .i_u_0(u0), .i_u_low(ulow), .i_u_high(uhigh),
        .o_gate_ah(a4h), .o_gate_al(a4l), .o_gate_bh(b4h), .o_gate_bl(b4l),
        .o_gate_ch(c4h), .o_gate_cl(c4l), .o_phase_state(p4), .o_fault(f4)
    );

    ac_motor_vector_gate #(.DEAD_CYCLES(0), .ZERO_MODE(1)) dut0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_enable(enable), .i_sector_in(sector),
        .i_u_0(u0), .i_u_low(ulow), .i_u_high(uhigh),
        .o_gate_ah(a0h), .o_gate_al(a0l), .o_gate_bh(b0h), .o_gate_bl(b0l),
        .o_gate_ch(c0h), .o_gate_cl(c0l), .o_phase_state(p0), .o_fault(f0)
    );

    wire [5:0] g4 = {a4h, a4l, b4h, b4l, c4h, c4l};
    wire [5:0] g0 = {a0h, a0l, b0h, b0l, c0h, c0l};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic z, input logic lo, input logic hi);
        sector = s; u0 = z; ulow = lo; uhigh = hi;
    endtask

    // Shoot-through guard, checked every cycle on both instances.
    always @(negedge clk) begin
        if (reset_n !== 1'bx) begin
            n_cmp++;
            assert (!((a4h & a4l) | (b4h & b4l) | (c4h & c4l) | (a0h & a0l) | (b0h & b0l) | (c0h & c0l)))
            else begin
                n_bad++;
                $error("FAIL shoot_through: g4=%b g0=%b required no leg with both gates on", g4, g0);
            end
        end
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0;
        drive(3'd0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("rst_g4", 8'(g4), 8'h00);
        chk("rst_p4", 8'(p4), 8'h00);
        chk("rst_f4", 8'(f4), 8'h00);
        chk("rst_g0", 8'(g0), 8'h00);

        // Sector 0 U_LOW -> V1 = 100; dead-time 4 on every leg
        reset_n = 1'b1; enable = 1'b1;
        drive(3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("v1_p4", 8'(p4), 8'b100);
        chk("v1_g4_k", 8'(g4), 8'h00);
        chk("v1_p0", 8'(p0), 8'b100);
        tick();
        chk("v1_g0_k1", 8'(g0), 8'b100101);
        for (int i = 1; i <= 4; i++) begin
            chk("v1_g4_dead", 8'(g4), 8'h00);
            tick();
        end
        chk("v1_g4_k5", 8'(g4), 8'b100101);

        // U_HIGH -> V2 = 110; only leg B switches
        drive(3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("v2_p4", 8'(p4), 8'b110);
        chk("v2_g4_k", 8'(g4), 8'b100101);
        tick();
        chk("v2_g4_k1", 8'(g4), 8'b100001);
        chk("v2_g0_k1", 8'(g0), 8'b101001);
        tick(); tick(); tick();
        chk("v2_g4_k4", 8'(g4), 8'b100001);
        tick();
        chk("v2_g4_k5", 8'(g4), 8'b101001);

        // U_0 after a two-high vector -> V7; only leg C switches
        drive(3'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("v7_p4", 8'(p4), 8'b111);
        chk("v7_p0", 8'(p0), 8'b111);
        tick();
        chk("v7_g4_k1", 8'(g4), 8'b101000);
        tick(); tick(); tick(); tick();
        chk("v7_g4_k5", 8'(g4), 8'b101010);

        // Leg A LOW then HIGH two clocks apart: dead-time restarts
        drive(3'd2, 1'b0, 1'b1, 1'b0);
        tick();
        chk("tog_p4_a", 8'(p4), 8'b010);
        tick();
        chk("tog_a_k1", 8'({a4h, a4l}), 8'b00);
        drive(3'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("tog_p4_b", 8'(p4), 8'b110);
        for (int i = 3; i <= 6; i++) begin
            tick();
            chk("tog_a_dead", 8'({a4h, a4l}), 8'b00);
        end
        tick();
        chk("tog_g4_k7", 8'(g4), 8'b101001);

        // Non-one-hot select -> sticky fault, gates off at the same edge
        drive(3'd0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("flt_f4", 8'(f4), 8'h01);
        chk("flt_g4", 8'(g4), 8'h00);
        chk("flt_g0", 8'(g0), 8'h00);
        chk("flt_p4", 8'(p4), 8'h00);
        drive(3'd0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("flt_stick_f4", 8'(f4), 8'h01);
        chk("flt_stick_g4", 8'(g4), 8'h00);
        chk("flt_stick_p0", 8'(p0), 8'h00);
        reset_n = 1'b0;
        tick();
        chk("flt_clr_f4", 8'(f4), 8'h00);

        // Out-of-range sector also faults
        reset_n = 1'b1;
        drive(3'd6, 1'b0, 1'b1, 1'b0);
        tick();
        chk("sec6_f4", 8'(f4), 8'h01);
        chk("sec6_f0", 8'(f0), 8'h01);
        reset_n = 1'b0;
        tick();

        // Reset mid-dead-time, then nearest zero after reset is V0
        reset_n = 1'b1;
        drive(3'd0, 1'b0, 1'b1, 1'b0);
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        chk("mid_rst_g4", 8'(g4), 8'h00);
        chk("mid_rst_p4", 8'(p4), 8'h00);
        chk("mid_rst_g0", 8'(g0), 8'h00);
        reset_n = 1'b1;
        drive(3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        chk("z2_p4", 8'(p4), 8'b000);
        chk("z1_p0", 8'(p0), 8'b111);
        tick();
        chk("z1_g0_k1", 8'(g0), 8'b101010);
        chk("z2_g4_k1", 8'(g4), 8'h00);
        tick(); tick(); tick(); tick();
        chk("z2_g4_k5", 8'(g4), 8'b010101);

        // Disable: targets off, gates off
        enable = 1'b0;
        tick();
        chk("dis_p4", 8'(p4), 8'h00);
        chk("dis_g4", 8'(g4), 8'h00);
        chk("dis_f4", 8'(f4), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
